// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags feeding Rename's tag allocation.
// Pops one tag per cycle and accepts up to two retired tags per cycle.
module phys_reg_free_list #(
  parameter int unsigned TAG_WIDTH = 6,
  parameter int unsigned NUM_TAGS  = 64,
  parameter int unsigned NUM_ARCH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_req,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  output logic                 alloc_valid,
  output logic                 alloc_grant,
  input  logic [TAG_WIDTH-1:0] freed_tag_1,
  input  logic [TAG_WIDTH-1:0] freed_tag_2,
  output logic [TAG_WIDTH:0]   free_count,
  output logic                 error
);

  localparam int unsigned CW        = TAG_WIDTH + 1;
  localparam int unsigned NUM_FREE  = NUM_TAGS - NUM_ARCH;
  localparam int unsigned MAX_COUNT = NUM_TAGS - 1;

  logic [TAG_WIDTH-1:0] mem [NUM_TAGS];
  logic [TAG_WIDTH-1:0] head;
  logic [TAG_WIDTH-1:0] tail;
  logic [CW-1:0]        count;
  logic                 err_q;

  logic                 v1;
  logic                 v2_raw;
  logic                 v2;
  logic                 dup;
  logic [1:0]           n_req;
  logic [1:0]           n_acc;
  logic [CW-1:0]        base;
  logic [CW-1:0]        room;
  logic                 overflow;
  logic [TAG_WIDTH-1:0] push_tag_a;

  assign alloc_valid = (count != '0);
  assign alloc_grant = alloc_req && alloc_valid;
  assign alloc_tag   = mem[head];
  assign free_count  = count;
  assign error       = err_q;

  // Push bookkeeping: a duplicate pair collapses to one push, excess drops tag_2 first.
  always_comb begin
    v1         = (freed_tag_1 != '0);
    v2_raw     = (freed_tag_2 != '0);
    dup        = v1 && v2_raw && (freed_tag_1 == freed_tag_2);
    v2         = v2_raw && !dup;
    n_req      = {1'b0, v1} + {1'b0, v2};
    base       = count - CW'(alloc_grant);
    room       = CW'(MAX_COUNT) - base;
    overflow   = (CW'(n_req) > room);
    n_acc      = overflow ? room[1:0] : n_req;
    push_tag_a = v1 ? freed_tag_1 : freed_tag_2;
  end

  // Pointers wrap naturally since NUM_TAGS is 2**TAG_WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        mem[i] <= (i < NUM_FREE) ? TAG_WIDTH'(NUM_ARCH + i) : '0;
      end
      head  <= '0;
      tail  <= TAG_WIDTH'(NUM_FREE);
      count <= CW'(NUM_FREE);
      err_q <= 1'b0;
    end else begin
      if (n_acc != 2'd0) begin
        mem[tail] <= push_tag_a;
      end
      if (n_acc == 2'd2) begin
        mem[tail + TAG_WIDTH'(1)] <= freed_tag_2;
      end
      if (alloc_grant) begin
        head <= head + TAG_WIDTH'(1);
      end
      tail  <= tail + TAG_WIDTH'(n_acc);
      count <= base + CW'(n_acc);
      if (overflow || dup) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed vectors plus random traffic against a queue model.
module tb_phys_reg_free_list;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_req;
  logic [5:0] alloc_tag;
  logic       alloc_valid;
  logic       alloc_grant;
  logic [5:0] freed_tag_1;
  logic [5:0] freed_tag_2;
  logic [6:0] free_count;
  logic       error;

  always #5 clk = ~clk;

  phys_reg_free_list dut (
    .clk         (clk),
    .reset       (reset),
    .alloc_req   (alloc_req),
    .alloc_tag   (alloc_tag),
    .alloc_valid (alloc_valid),
    .alloc_grant (alloc_grant),
    .freed_tag_1 (freed_tag_1),
    .freed_tag_2 (freed_tag_2),
    .free_count  (free_count),
    .error       (error)
  );

  int errors = 0;
  int checks = 0;
  int q[$];
  bit m_err;

  typedef struct {
    logic       req;
    logic [5:0] f1;
    logic [5:0] f2;
    logic       v;
    logic       g;
    logic [5:0] tag;
    logic [6:0] cnt;
    logic       err;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(32 + i);
    m_err = 1'b0;
  endtask

  // Drive one cycle, check outputs against the model, advance model past the edge.
  task automatic cycle(input logic rst, input logic req, input logic [5:0] a, input logic [5:0] b,
                       output logic [5:0] s_tag, output logic s_v, output logic s_g,
                       output logic [6:0] s_cnt, output logic s_err);
    int t[2];
    int n;
    reset = rst; alloc_req = req; freed_tag_1 = a; freed_tag_2 = b;
    #2;
    s_tag = alloc_tag; s_v = alloc_valid; s_g = alloc_grant; s_cnt = free_count; s_err = error;
    chk("alloc_valid", 32'(alloc_valid), 32'(q.size() != 0));
    chk("alloc_grant", 32'(alloc_grant), 32'(req && q.size() != 0));
    chk("free_count", 32'(free_count), 32'(q.size()));
    chk("error", 32'(error), 32'(m_err));
    if (q.size() != 0) chk("alloc_tag", 32'(alloc_tag), 32'(q[0]));
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (req && q.size() != 0) void'(q.pop_front());
      n = 0;
      if (a != 0) begin t[n] = int'(a); n++; end
      if (b != 0) begin
        if (a == b) m_err = 1'b1;
        else begin t[n] = int'(b); n++; end
      end
      for (int k = 0; k < n; k++) begin
        if (q.size() < 63) q.push_back(t[k]);
        else m_err = 1'b1;
      end
    end
  endtask

  logic [5:0] s_tag;
  logic       s_v, s_g, s_err;
  logic [6:0] s_cnt;

  task automatic go(input logic rst, input logic req, input logic [5:0] a, input logic [5:0] b);
    cycle(rst, req, a, b, s_tag, s_v, s_g, s_cnt, s_err);
  endtask

  initial begin
    tbl[0] = '{1'b1, 6'd5,  6'd9,  1'b0, 1'b0, 6'd0,  7'd0, 1'b0};
    tbl[1] = '{1'b0, 6'd0,  6'd0,  1'b1, 1'b0, 6'd5,  7'd2, 1'b0};
    tbl[2] = '{1'b1, 6'd0,  6'd0,  1'b1, 1'b1, 6'd5,  7'd2, 1'b0};
    tbl[3] = '{1'b1, 6'd0,  6'd0,  1'b1, 1'b1, 6'd9,  7'd1, 1'b0};
    tbl[4] = '{1'b0, 6'd0,  6'd17, 1'b0, 1'b0, 6'd0,  7'd0, 1'b0};
    tbl[5] = '{1'b0, 6'd12, 6'd12, 1'b1, 1'b0, 6'd17, 7'd1, 1'b0};
    tbl[6] = '{1'b0, 6'd0,  6'd0,  1'b1, 1'b0, 6'd17, 7'd2, 1'b1};
    tbl[7] = '{1'b1, 6'd0,  6'd0,  1'b1, 1'b1, 6'd17, 7'd2, 1'b1};
    tbl[8] = '{1'b0, 6'd0,  6'd0,  1'b1, 1'b0, 6'd12, 7'd1, 1'b1};

    reset = 1'b1; alloc_req = 1'b0; freed_tag_1 = '0; freed_tag_2 = '0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset state.
    go(1'b0, 1'b0, 6'd0, 6'd0);
    chk("reset_tag", 32'(s_tag), 32'd32);
    chk("reset_valid", 32'(s_v), 32'd1);
    chk("reset_count", 32'(s_cnt), 32'd32);
    chk("reset_error", 32'(s_err), 32'd0);

    // Drain all 32 tags, then see empty.
    for (int i = 0; i < 33; i++) begin
      go(1'b0, 1'b1, 6'd0, 6'd0);
      if (i < 32) chk("drain_tag", 32'(s_tag), 32'(32 + i));
      else begin
        chk("empty_valid", 32'(s_v), 32'd0);
        chk("empty_grant", 32'(s_g), 32'd0);
        chk("empty_count", 32'(s_cnt), 32'd0);
      end
    end

    // Directed vectors from empty: push/no-bypass, tag_2-only, duplicate.
    for (int i = 0; i < 9; i++) begin
      go(1'b0, tbl[i].req, tbl[i].f1, tbl[i].f2);
      chk("vec_valid", 32'(s_v), 32'(tbl[i].v));
      chk("vec_grant", 32'(s_g), 32'(tbl[i].g));
      chk("vec_count", 32'(s_cnt), 32'(tbl[i].cnt));
      chk("vec_error", 32'(s_err), 32'(tbl[i].err));
      if (tbl[i].v) chk("vec_tag", 32'(s_tag), 32'(tbl[i].tag));
    end

    // Steady state: alloc and free 40 every cycle across pointer wrap.
    go(1'b1, 1'b0, 6'd0, 6'd0);
    for (int i = 0; i < 100; i++) begin
      go(1'b0, 1'b1, 6'd40, 6'd0);
      chk("steady_count", 32'(s_cnt), 32'd32);
      chk("steady_error", 32'(s_err), 32'd0);
      if (i >= 32) chk("steady_tag", 32'(s_tag), 32'd40);
    end

    // Overflow at 62: 7 accepted, 8 dropped, error sticky.
    go(1'b1, 1'b0, 6'd0, 6'd0);
    for (int i = 0; i < 15; i++) go(1'b0, 1'b0, 6'(2 * i + 1), 6'(2 * i + 2));
    go(1'b0, 1'b0, 6'd7, 6'd8);
    chk("ovf_pre_count", 32'(s_cnt), 32'd62);
    go(1'b0, 1'b1, 6'd0, 6'd0);
    chk("ovf_count", 32'(s_cnt), 32'd63);
    chk("ovf_error", 32'(s_err), 32'd1);
    go(1'b0, 1'b0, 6'd0, 6'd0);
    chk("ovf_sticky", 32'(s_err), 32'd1);
    chk("ovf_after_pop", 32'(s_cnt), 32'd62);
    for (int i = 0; i < 63; i++) go(1'b0, 1'b1, 6'd0, 6'd0);

    // Reset mid-operation discards pending req/free.
    go(1'b1, 1'b0, 6'd0, 6'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) go(1'b0, 1'b1, 6'd3, 6'd3);
      else if (i == 5) go(1'b0, 1'b1, 6'd4, 6'd6);
      else go(1'b0, 1'b1, 6'd0, 6'd0);
    end
    go(1'b1, 1'b1, 6'd11, 6'd13);
    go(1'b0, 1'b0, 6'd0, 6'd0);
    chk("mid_reset_tag", 32'(s_tag), 32'd32);
    chk("mid_reset_count", 32'(s_cnt), 32'd32);
    chk("mid_reset_error", 32'(s_err), 32'd0);

    // Random traffic in alloc-heavy, free-heavy and balanced phases.
    for (int r = 0; r < 3000; r++) begin
      int mode;
      logic rq, rs;
      logic [5:0] a, b;
      mode = (r / 250) % 3;
      rs = ($urandom_range(0, 299) == 0);
      case (mode)
        0: rq = ($urandom_range(0, 9) < 9);
        1: rq = ($urandom_range(0, 9) < 2);
        default: rq = ($urandom_range(0, 9) < 7);
      endcase
      a = ($urandom_range(0, 2) != 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      b = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      if (mode == 0 && $urandom_range(0, 1) == 0) b = 6'd0;
      if ($urandom_range(0, 49) == 0) b = a;
      go(rs, rq, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
